// File: rtl/lmdpl_linear_vec.sv
// WIDTH-lane two-share dual-rail (LMDPL) linear cell: XOR / pass-A / pass-B with rail-swap
// inversions, optional registered pipeline and fault flags. Define LMDPL_FAULT_CNT_EN for fault_cnt.
module lmdpl_linear_vec #(
   parameter int unsigned WIDTH        = 4,
   parameter int unsigned PIPE_DEPTH   = 2,
   parameter int unsigned NoConfigBits = 3 * WIDTH + 3
) (
   input  logic                    UserCLK,
   input  logic                    rst,
   input  logic [NoConfigBits-1:0] ConfigBits,
   input  logic                    in_valid,
   input  logic [WIDTH-1:0]        A0_t,
   input  logic [WIDTH-1:0]        A0_f,
   input  logic [WIDTH-1:0]        B0_t,
   input  logic [WIDTH-1:0]        B0_f,
   input  logic [WIDTH-1:0]        A1_t,
   input  logic [WIDTH-1:0]        A1_f,
   input  logic [WIDTH-1:0]        B1_t,
   input  logic [WIDTH-1:0]        B1_f,
   output logic [WIDTH-1:0]        Z0_t,
   output logic [WIDTH-1:0]        Z0_f,
   output logic [WIDTH-1:0]        Z1_t,
   output logic [WIDTH-1:0]        Z1_f,
   output logic                    out_valid,
   output logic                    F_masked0,
   output logic                    F_masked1,
   output logic                    F_sticky
`ifdef LMDPL_FAULT_CNT_EN
   ,
   output logic [7:0]              fault_cnt
`endif
);

   localparam int unsigned StW = 4 * WIDTH + 1;

   logic [WIDTH-1:0] ca, cb, cz;
   logic [1:0]       op;
   logic             ff;

   always_comb begin
      ca = '0;
      cb = '0;
      cz = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         ca[i] = ConfigBits[3*i];
         cb[i] = ConfigBits[3*i+1];
         cz[i] = ConfigBits[3*i+2];
      end
      op = ConfigBits[3*WIDTH +: 2];
      ff = ConfigBits[3*WIDTH+2];
   end

   // Dual-rail XOR keeps spacers (00) as spacers and propagates an invalid 11 operand.
   function automatic logic [2*WIDTH-1:0] lin_op(input logic [1:0]       sel,
                                                 input logic [WIDTH-1:0] at,
                                                 input logic [WIDTH-1:0] af,
                                                 input logic [WIDTH-1:0] bt,
                                                 input logic [WIDTH-1:0] bf);
      logic [WIDTH-1:0] zt, zf;
      case (sel)
         2'b01: begin
            zt = at;
            zf = af;
         end
         2'b10: begin
            zt = bt;
            zf = bf;
         end
         default: begin
            zt = (at & bf) | (af & bt);
            zf = (at & bt) | (af & bf);
         end
      endcase
      return {zt, zf};
   endfunction

   logic [WIDTH-1:0] a0t_s, a0f_s, b0t_s, b0f_s;
   logic [WIDTH-1:0] res0_t, res0_f, res1_t, res1_f;
   logic [WIDTH-1:0] r1t_raw, r1f_raw;

   always_comb begin
      // Inversion is a rail swap, so no rail is ever logically negated.
      a0t_s = (A0_t & ~ca) | (A0_f & ca);
      a0f_s = (A0_f & ~ca) | (A0_t & ca);
      b0t_s = (B0_t & ~cb) | (B0_f & cb);
      b0f_s = (B0_f & ~cb) | (B0_t & cb);
      {res0_t, res0_f}   = lin_op(op, a0t_s, a0f_s, b0t_s, b0f_s);
      {r1t_raw, r1f_raw} = lin_op(op, A1_t, A1_f, B1_t, B1_f);
      res1_t = (r1t_raw & ~cz) | (r1f_raw & cz);
      res1_f = (r1f_raw & ~cz) | (r1t_raw & cz);
   end

   logic [StW-1:0] pipe_q [PIPE_DEPTH];

   always_ff @(posedge UserCLK) begin
      if (rst) begin
         for (int i = 0; i < int'(PIPE_DEPTH); i++) begin
            pipe_q[i] <= '0;
         end
      end else begin
         pipe_q[0] <= {in_valid, res0_t, res0_f, res1_t, res1_f};
         for (int i = 1; i < int'(PIPE_DEPTH); i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
      end
   end

   always_comb begin
      Z0_t      = res0_t;
      Z0_f      = res0_f;
      Z1_t      = res1_t;
      Z1_f      = res1_f;
      out_valid = in_valid;
      F_masked0 = 1'b0;
      F_masked1 = 1'b0;
      if (ff) begin
         {out_valid, Z0_t, Z0_f, Z1_t, Z1_f} = pipe_q[PIPE_DEPTH-1];
         // A lane is faulty when both rails agree; spacers only count while out_valid.
         F_masked0 = out_valid & (|(~(Z0_t ^ Z0_f)));
         F_masked1 = out_valid & (|(~(Z1_t ^ Z1_f)));
      end
   end

   logic sticky_q, sticky_d;

   always_comb begin
      sticky_d = sticky_q | F_masked0 | F_masked1;
   end

   always_ff @(posedge UserCLK) begin
      if (rst) begin
         sticky_q <= 1'b0;
      end else begin
         sticky_q <= sticky_d;
      end
   end

   assign F_sticky = sticky_q;

`ifdef LMDPL_FAULT_CNT_EN
   logic [7:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if ((F_masked0 | F_masked1) && (cnt_q != 8'hFF)) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge UserCLK) begin
      if (rst) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign fault_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_lmdpl_linear_vec.sv
// Scoreboard bench for lmdpl_linear_vec (WIDTH=4, PIPE_DEPTH=2); checks fault_cnt when
// LMDPL_FAULT_CNT_EN is defined.
module tb_lmdpl_linear_vec;

   localparam int unsigned W   = 4;
   localparam int unsigned NCB = 3 * W + 3;

   logic           UserCLK = 1'b0;
   logic           rst = 1'b1;
   logic [NCB-1:0] ConfigBits = '0;
   logic           in_valid = 1'b0;
   logic [W-1:0]   A0_t = '0, A0_f = '0, B0_t = '0, B0_f = '0;
   logic [W-1:0]   A1_t = '0, A1_f = '0, B1_t = '0, B1_f = '0;
   logic [W-1:0]   Z0_t, Z0_f, Z1_t, Z1_f;
   logic           out_valid, F_masked0, F_masked1, F_sticky;
`ifdef LMDPL_FAULT_CNT_EN
   logic [7:0]     fault_cnt;
`endif

   always #5 UserCLK = ~UserCLK;

   lmdpl_linear_vec #(
      .WIDTH      (W),
      .PIPE_DEPTH (2)
   ) dut (
      .UserCLK    (UserCLK),
      .rst        (rst),
      .ConfigBits (ConfigBits),
      .in_valid   (in_valid),
      .A0_t       (A0_t),
      .A0_f       (A0_f),
      .B0_t       (B0_t),
      .B0_f       (B0_f),
      .A1_t       (A1_t),
      .A1_f       (A1_f),
      .B1_t       (B1_t),
      .B1_f       (B1_f),
      .Z0_t       (Z0_t),
      .Z0_f       (Z0_f),
      .Z1_t       (Z1_t),
      .Z1_f       (Z1_f),
      .out_valid  (out_valid),
      .F_masked0  (F_masked0),
      .F_masked1  (F_masked1),
      .F_sticky   (F_sticky)
`ifdef LMDPL_FAULT_CNT_EN
      ,
      .fault_cnt  (fault_cnt)
`endif
   );

   typedef struct {
      logic [3:0] z0t, z0f, z1t, z1f;
      logic       fm0, fm1;
      int         cyc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   lat = 2;
   bit   mon_en = 1'b0;

   always @(posedge UserCLK) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, req, cyc);
      end
   endtask

   function automatic logic [NCB-1:0] mk_cfg(input logic [W-1:0] ca, input logic [W-1:0] cb,
                                             input logic [W-1:0] cz, input logic [1:0] op,
                                             input logic ff);
      logic [NCB-1:0] c;
      c = '0;
      for (int i = 0; i < int'(W); i++) begin
         c[3*i]   = ca[i];
         c[3*i+1] = cb[i];
         c[3*i+2] = cz[i];
      end
      c[3*W +: 2] = op;
      c[3*W+2]    = ff;
      return c;
   endfunction

   task automatic tick();
      @(posedge UserCLK);
      #1;
   endtask

   task automatic drive(input logic [3:0] a0t, a0f, b0t, b0f, a1t, a1f, b1t, b1f);
      A0_t = a0t; A0_f = a0f; B0_t = b0t; B0_f = b0f;
      A1_t = a1t; A1_f = a1f; B1_t = b1t; B1_f = b1f;
      in_valid = 1'b1;
   endtask

   task automatic issue(input logic [3:0] a0t, a0f, b0t, b0f, a1t, a1f, b1t, b1f,
                        input logic [3:0] ez0t, ez0f, ez1t, ez1f, input logic efm0, efm1);
      exp_t e;
      drive(a0t, a0f, b0t, b0f, a1t, a1f, b1t, b1f);
      e.z0t = ez0t; e.z0f = ez0f; e.z1t = ez1t; e.z1f = ez1f;
      e.fm0 = efm0; e.fm1 = efm1;
      e.cyc = cyc + lat;
      sb.push_back(e);
      tick();
   endtask

   task automatic idle();
      A0_t = '0; A0_f = '0; B0_t = '0; B0_f = '0;
      A1_t = '0; A1_f = '0; B1_t = '0; B1_f = '0;
      in_valid = 1'b0;
      tick();
   endtask

   task automatic chk_reset_outs();
      chk("rst_z0t", Z0_t, 0);
      chk("rst_z0f", Z0_f, 0);
      chk("rst_z1t", Z1_t, 0);
      chk("rst_z1f", Z1_f, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_fm0", F_masked0, 0);
      chk("rst_fm1", F_masked1, 0);
      chk("rst_sticky", F_sticky, 0);
`ifdef LMDPL_FAULT_CNT_EN
      chk("rst_fault_cnt", fault_cnt, 0);
`endif
   endtask

   // Config is only changed while rst is high; idle first so stale pipeline data drains.
   task automatic do_reset(input logic [NCB-1:0] cfg, input int l);
      repeat (3) idle();
      ConfigBits = cfg;
      lat = l;
      rst = 1'b1;
      tick();
      tick();
      chk_reset_outs();
      rst = 1'b0;
      mon_en = 1'b1;
   endtask

   always @(negedge UserCLK) begin
      exp_t e;
      if (mon_en) begin
         if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_valid actual=1 required=0 cycle=%0d", cyc);
            end else begin
               e = sb.pop_front();
               chk("out_cycle", cyc, e.cyc);
               chk("z0_t", Z0_t, e.z0t);
               chk("z0_f", Z0_f, e.z0f);
               chk("z1_t", Z1_t, e.z1t);
               chk("z1_f", Z1_f, e.z1f);
               chk("f_masked0", F_masked0, e.fm0);
               chk("f_masked1", F_masked1, e.fm1);
            end
         end else begin
            chk("idle_fm0", F_masked0, 0);
            chk("idle_fm1", F_masked1, 0);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // XOR, registered, no swaps
      do_reset(mk_cfg(4'h0, 4'h0, 4'h0, 2'b00, 1'b1), 2);
      issue(4'b1010, 4'b0101, 4'b0110, 4'b1001, 4'h0, 4'hF, 4'h0, 4'hF,
            4'b1100, 4'b0011, 4'b0000, 4'b1111, 1'b0, 1'b0);
      repeat (3) idle();

      // CA[0] inverts A0 lane 0, CZ[3] swaps Z1 lane 3
      do_reset(mk_cfg(4'b0001, 4'h0, 4'b1000, 2'b00, 1'b1), 2);
      issue(4'b0001, 4'b1110, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF,
            4'b0000, 4'b1111, 4'b1000, 4'b0111, 1'b0, 1'b0);
      repeat (3) idle();

      // pass-B with CB[1]
      do_reset(mk_cfg(4'h0, 4'b0010, 4'h0, 2'b10, 1'b1), 2);
      issue(4'b1100, 4'b0011, 4'b1010, 4'b0101, 4'b0011, 4'b1100, 4'b0101, 4'b1010,
            4'b1000, 4'b0111, 4'b0101, 4'b1010, 1'b0, 1'b0);
      repeat (3) idle();

      // reserved OP behaves as XOR; back-to-back symbols
      do_reset(mk_cfg(4'h0, 4'h0, 4'h0, 2'b11, 1'b1), 2);
      issue(4'b1100, 4'b0011, 4'b1010, 4'b0101, 4'b0011, 4'b1100, 4'b0101, 4'b1010,
            4'b0110, 4'b1001, 4'b0110, 4'b1001, 1'b0, 1'b0);
      issue(4'b1111, 4'b0000, 4'b0001, 4'b1110, 4'h0, 4'hF, 4'b1111, 4'b0000,
            4'b1110, 4'b0001, 4'b1111, 4'b0000, 1'b0, 1'b0);
      repeat (3) idle();

      // fault on share-1 lane 2 for one valid cycle
      do_reset(mk_cfg(4'h0, 4'h0, 4'h0, 2'b00, 1'b1), 2);
      issue(4'h0, 4'hF, 4'h0, 4'hF, 4'b0100, 4'hF, 4'h0, 4'hF,
            4'b0000, 4'b1111, 4'b0100, 4'b1111, 1'b0, 1'b1);
      idle();
      chk("sticky_before_set", F_sticky, 0);
      idle();
      chk("sticky_set", F_sticky, 1);
`ifdef LMDPL_FAULT_CNT_EN
      chk("fault_cnt_one", fault_cnt, 1);
`endif
      repeat (4) idle();
      chk("sticky_held", F_sticky, 1);

      // combinational pass-A with CA on lanes 0 and 2; invalid symbols raise no flag
      do_reset(mk_cfg(4'b0101, 4'h0, 4'h0, 2'b01, 1'b0), 0);
      issue(4'b0011, 4'b1100, 4'b1111, 4'b0000, 4'b1001, 4'b0110, 4'h0, 4'hF,
            4'b0110, 4'b1001, 4'b1001, 4'b0110, 1'b0, 1'b0);
      issue(4'b0010, 4'b1111, 4'h0, 4'hF, 4'b1000, 4'b1000, 4'h0, 4'hF,
            4'b0111, 4'b1010, 4'b1000, 4'b1000, 1'b0, 1'b0);
      idle();
      chk("ff0_valid_follows", out_valid, 0);
      chk("ff0_no_sticky", F_sticky, 0);
      repeat (3) idle();

      // mid-stream reset flushes in-flight symbols
      do_reset(mk_cfg(4'h0, 4'h0, 4'h0, 2'b00, 1'b1), 2);
      issue(4'b0011, 4'b1100, 4'b0101, 4'b1010, 4'b1111, 4'b0000, 4'h0, 4'hF,
            4'b0110, 4'b1001, 4'b1111, 4'b0000, 1'b0, 1'b0);
      drive(4'b1111, 4'h0, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF);
      tick();
      drive(4'b0101, 4'b1010, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF);
      rst = 1'b1;
      tick();
      chk_reset_outs();
      rst = 1'b0;
      repeat (4) idle();
      issue(4'b1001, 4'b0110, 4'h0, 4'hF, 4'h0, 4'hF, 4'b0001, 4'b1110,
            4'b1001, 4'b0110, 4'b0001, 4'b1110, 1'b0, 1'b0);
      repeat (3) idle();

`ifdef LMDPL_FAULT_CNT_EN
      // counter saturation
      do_reset(mk_cfg(4'h0, 4'h0, 4'h0, 2'b00, 1'b1), 2);
      for (int n = 0; n < 300; n++) begin
         issue(4'h0, 4'hF, 4'h0, 4'hF, 4'b0100, 4'hF, 4'h0, 4'hF,
               4'b0000, 4'b1111, 4'b0100, 4'b1111, 1'b0, 1'b1);
      end
      repeat (3) idle();
      chk("fault_cnt_sat", fault_cnt, 255);
      repeat (5) idle();
      chk("fault_cnt_hold", fault_cnt, 255);
`endif

      repeat (5) idle();
      chk("sb_drain", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lmdpl_linear_vec.md
# lmdpl_linear_vec

Parametrised, WIDTH-lane, two-share dual-rail (LMDPL) linear cell for the SAUBER masked fabric tiles. Each lane combines two input shares per share domain in dual-rail form: t/f rails, with a valid symbol having exactly one rail high. Supported operations are XOR, pass-A and pass-B. Per-lane input and output inversions are applied by rail swapping, so no rail is ever logically inverted. An optional PIPE_DEPTH-stage register pipeline carries valid tracking, and dual-rail fault detection with sticky fault flags is provided. It is the next-generation replacement for the single-bit linear LMDPL BEL.

## Interface
Parameters:
- WIDTH, 4, number of independent lanes (≥1).
- PIPE_DEPTH, 2, register stages when registered mode is selected (≥1).
- NoConfigBits, 3*WIDTH+3, configuration width; fixed by WIDTH.

Ports:
- UserCLK  in  1  clock, shared/external.
- rst  in  1  synchronous, active-high reset, shared/external.
- ConfigBits  in  NoConfigBits  global configuration, static during operation.
- in_valid  in  1  input symbols valid this cycle.
- A0_t, A0_f, B0_t, B0_f  in  WIDTH each  share-0 operands, dual-rail.
- A1_t, A1_f, B1_t, B1_f  in  WIDTH each  share-1 operands, dual-rail.
- Z0_t, Z0_f, Z1_t, Z1_f  out  WIDTH each  result shares, dual-rail.
- out_valid  out  1  Z valid.
- F_masked0, F_masked1  out  1 each  combinational fault indication for share 0 and share 1 at the output (external).
- F_sticky  out  1  latched OR of all faults since reset (external).
- fault_cnt  out  8  saturating fault-cycle count (external; only with LMDPL_FAULT_CNT_EN).

## Operation
- ConfigBits map:
  - [3i] = CA[i]: swap share-0 A rails of lane i.
  - [3i+1] = CB[i]: swap share-0 B rails of lane i.
  - [3i+2] = CZ[i]: swap share-1 result rails of lane i.
  - [3W+1:3W] = OP.
  - [3W+2] = FF.
- OP encoding:
  - 00: XOR, Z = A⊕B in dual-rail, per share.
  - 01: pass A.
  - 10: pass B.
  - 11: reserved; behaves as XOR.
- Swaps apply only to share 0 inputs (CA/CB) and share 1 output (CZ); share-1 inputs and share-0 output pass unswapped.
- A swap applied to a spacer (00) or invalid symbol (11) is a no-op.
- Lane result rails from the combinational core are `res*`.
- FF=0 (combinational mode):
  - Z = res.
  - out_valid = in_valid.
  - F_masked0/1 = 0.
  - The pipeline still clocks but is unobserved.
- FF=1 (registered mode):
  - res and in_valid enter a PIPE_DEPTH-deep register chain.
  - Z and out_valid are driven from the last stage.
- Fault, FF=1 only:
  - Lane share s is faulty when last-stage Zs_t == Zs_f.
  - F_masked_s = out_valid & FF & (OR over lanes of that condition).
- F_sticky is set the cycle after any F_masked_s = 1 and clears only on rst.
- Reset: all pipeline rails are 0 (spacer), valid bits are 0, F_sticky = 0, fault_cnt = 0.
- Spacers present while out_valid = 0 are never faults.

## Timing
- FF=0: latency 0. FF=1: latency PIPE_DEPTH cycles from in_valid to out_valid.
- Throughput is one symbol per cycle; there is no back-pressure.
- Output reset values, FF=1: Z* = 0, out_valid = 0, F_masked* = 0, F_sticky = 0, fault_cnt = 0. These hold in the cycle after rst is sampled high.
- rst asserted mid-stream flushes all in-flight symbols. out_valid stays 0 until PIPE_DEPTH cycles after the first post-reset in_valid.
- rst has priority over data and over F_sticky set in the same cycle.
- Changing FF or OP while data is in flight is undefined; software changes configuration only while in reset.

## Configuration
- Macro LMDPL_FAULT_CNT_EN, defined: fault_cnt increments by 1 on each cycle where F_masked0|F_masked1. It saturates at 255 and clears on rst.
- Undefined: fault_cnt port and counter are absent; F_sticky still exists.

## Test plan
- Reset then FF=1, OP=00, WIDTH=4, all swaps 0: A0=1010, B0=0110 (dual-rail), share-1 zero. Required: out_valid rises exactly 2 cycles later; Z0 = 1100 with Z0_f = ~Z0_t; no faults.
- CA[0]=1, CZ[3]=1, OP=00: A0=0001, B0=0000. Required: Z0 lane 0 = 0 (inverted A), and Z1 lane 3 shows t/f swapped versus the CZ=0 run.
- FF=1: inject A1_t=A1_f=1 on lane 2 with in_valid=1 for one cycle. Required: F_masked1 pulses for one cycle, 2 cycles later; F_sticky = 1 from the next cycle until rst. With the macro, fault_cnt = 1.
- FF=0, OP=01: Z equals the swapped A combinationally in the same cycle; out_valid = in_valid; F_masked* stay 0 even when an invalid 11 symbol is applied.
- Stream 3 valid symbols, assert rst on the cycle after the second. Required: all outputs 0 next cycle; no out_valid for flushed symbols.
- With the macro, hold a fault for 300 valid cycles. Required: fault_cnt = 255 and stays there.
